// File: rtl/top.sv
// UART message printer: reads words from host memory over a UART link,
// prints each byte with a PRINT command until a zero byte, then halts.
module top #(
  parameter int unsigned CLK       = 50,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic clk,
  input  logic res_n,
  output logic tx,
  input  logic rx
);

  localparam int unsigned DIV      = CLK * 1000000 / BAUD_RATE;
  localparam int unsigned CW       = $clog2(DIV);
  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_PRINT = 8'h03;
  localparam logic [7:0] CMD_HLT   = 8'h04;

  typedef enum logic [2:0] {
    FETCH_CMD, FETCH_ADDR, FETCH_DATA, SCAN, PRINT_CMD, PRINT_CHAR, HALT, DONE
  } state_t;

  // transmitter
  logic          tx_start;
  logic [7:0]    tx_byte;
  logic          tx_busy;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [9:0]    tx_sh;
  logic          tx_ready;

  // Bit slot 10 is the extra idle period that keeps frames apart.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '1;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx_busy <= 1'b1;
        tx_sh   <= {2'b11, tx_byte};
        tx      <= 1'b0;
        tx_cnt  <= '0;
        tx_bit  <= '0;
      end
    end else if (tx_cnt == BIT_END) begin
      tx_cnt <= '0;
      if (tx_bit == 4'd10) begin
        tx_busy <= 1'b0;
      end else begin
        tx_bit <= tx_bit + 4'd1;
        tx     <= tx_sh[0];
        tx_sh  <= {1'b1, tx_sh[9:1]};
      end
    end else begin
      tx_cnt <= tx_cnt + CW'(1);
    end
  end

  assign tx_ready = !tx_busy && !tx_start;

  // receiver
  logic          rx_meta, rx_s, rx_prev;
  logic          rx_act;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic [7:0]    rx_data;
  logic          rx_valid;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      rx_act   <= 1'b0;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      rx_prev  <= rx_s;
      rx_valid <= 1'b0;
      if (!rx_act) begin
        if (rx_prev && !rx_s) begin
          rx_act <= 1'b1;
          rx_cnt <= '0;
          rx_bit <= '0;
        end
      end else if (rx_bit == 4'd0) begin
        // start bit must still be low at half-bit, otherwise it was a glitch
        if (rx_cnt == HALF_END) begin
          rx_cnt <= '0;
          if (rx_s) rx_act <= 1'b0;
          else      rx_bit <= 4'd1;
        end else begin
          rx_cnt <= rx_cnt + CW'(1);
        end
      end else if (rx_cnt == BIT_END) begin
        rx_cnt <= '0;
        if (rx_bit == 4'd9) begin
          rx_act <= 1'b0;
          if (rx_s) begin
            rx_valid <= 1'b1;
            rx_data  <= rx_sh;
          end
        end else begin
          rx_sh  <= {rx_s, rx_sh[7:1]};
          rx_bit <= rx_bit + 4'd1;
        end
      end else begin
        rx_cnt <= rx_cnt + CW'(1);
      end
    end
  end

  // controller
  state_t      state;
  logic [31:0] ptr;
  logic [31:0] word;
  logic [1:0]  idx;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state    <= FETCH_CMD;
      ptr      <= '0;
      word     <= '0;
      idx      <= '0;
      tx_start <= 1'b0;
      tx_byte  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        FETCH_CMD: if (tx_ready) begin
          tx_start <= 1'b1;
          tx_byte  <= CMD_READ;
          idx      <= '0;
          state    <= FETCH_ADDR;
        end
        FETCH_ADDR: if (tx_ready) begin
          tx_start <= 1'b1;
          tx_byte  <= ptr[{idx, 3'b000} +: 8];
          idx      <= idx + 2'd1;
          if (idx == 2'd3) state <= FETCH_DATA;
        end
        // b0 arrives first and ends up in word[7:0] after four shifts
        FETCH_DATA: if (rx_valid) begin
          word <= {rx_data, word[31:8]};
          idx  <= idx + 2'd1;
          if (idx == 2'd3) state <= SCAN;
        end
        SCAN: begin
          if (word[31:24] == 8'h00) state <= HALT;
          else                      state <= PRINT_CMD;
        end
        PRINT_CMD: if (tx_ready) begin
          tx_start <= 1'b1;
          tx_byte  <= CMD_PRINT;
          state    <= PRINT_CHAR;
        end
        PRINT_CHAR: if (tx_ready) begin
          tx_start <= 1'b1;
          tx_byte  <= word[31:24];
          word     <= {word[23:0], 8'h00};
          idx      <= idx + 2'd1;
          if (idx == 2'd3) begin
            ptr   <= ptr + 32'd4;
            state <= FETCH_CMD;
          end else begin
            state <= SCAN;
          end
        end
        HALT: if (tx_ready) begin
          tx_start <= 1'b1;
          tx_byte  <= CMD_HLT;
          state    <= DONE;
        end
        DONE: ;
        default: state <= DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_top.sv
// Bench for the UART message printer: plays the host side of the link
// against random and fixed memory images and checks the transmitted stream.
module tb_top;

  localparam int DIV = 10;

  logic clk = 1'b0;
  logic res_n = 1'b0;
  logic rx = 1'b1;
  logic tx;

  top #(.CLK(1), .BAUD_RATE(100000)) dut (
    .clk  (clk),
    .res_n(res_n),
    .tx   (tx),
    .rx   (rx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [7:0] txq[$];
  bit okq[$];
  int last_start = 0;
  bit have_last = 0;
  bit stuck = 0;
  logic [7:0] mem [0:63];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame decoder: one frame is 10 bits of DIV clocks, each bit must be flat.
  initial begin : mon
    int t0;
    bit ok;
    logic [99:0] s;
    logic [7:0] b;
    forever begin
      @(posedge clk); #1;
      if (res_n && tx === 1'b0) begin
        t0 = cyc;
        s[0] = tx;
        for (int i = 1; i < 10 * DIV; i++) begin
          @(posedge clk); #1;
          s[i] = tx;
        end
        ok = 1'b1;
        for (int k = 0; k < 10; k++)
          for (int j = 1; j < DIV; j++)
            if (s[k*DIV+j] !== s[k*DIV]) ok = 1'b0;
        if (s[0] !== 1'b0 || s[9*DIV+DIV/2] !== 1'b1) ok = 1'b0;
        for (int k = 0; k < 8; k++) b[k] = s[(k+1)*DIV + DIV/2];
        if (have_last && (t0 - last_start) < 11 * DIV) ok = 1'b0;
        last_start = t0;
        have_last = 1'b1;
        txq.push_back(b);
        okq.push_back(ok);
      end
    end
  end

  task automatic expect_tx(input string tag, input logic [7:0] exp);
    int n;
    logic [7:0] b;
    bit f;
    if (stuck) return;
    n = 0;
    while (txq.size() == 0 && n < 3000) begin
      tick(1);
      n++;
    end
    check({tag, "_avail"}, 32'(txq.size() != 0), 32'd1);
    if (txq.size() == 0) begin
      stuck = 1'b1;
    end else begin
      b = txq.pop_front();
      f = okq.pop_front();
      check(tag, 32'(b), 32'(exp));
      check({tag, "_frame"}, 32'(f), 32'd1);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop);
    rx = 1'b0;
    tick(DIV);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      tick(DIV);
    end
    rx = stop;
    tick(DIV);
    rx = 1'b1;
    tick(DIV);
  endtask

  task automatic clear_mon();
    txq.delete();
    okq.delete();
    have_last = 1'b0;
    stuck = 1'b0;
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    tick(3);
    check("rst_tx", 32'(tx), 32'd1);
    res_n = 1'b1;
    clear_mon();
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(1, 255));
    for (int i = 0; i < s.len(); i++) mem[i] = s[i];
    mem[s.len()] = 8'h00;
  endtask

  task automatic load_rand(input int len);
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(1, 255));
    mem[len] = 8'h00;
  endtask

  // Host model: answer each READ from mem (big-endian word, b0 sent first)
  // and expect PRINT for every nonzero byte in address order, HLT at the zero.
  task automatic run_program(input bit bad_stop);
    logic [31:0] ptr;
    bit done;
    ptr = '0;
    done = 1'b0;
    while (!done && !stuck) begin
      expect_tx("read_cmd", 8'h01);
      for (int a = 0; a < 4; a++) expect_tx("read_addr", ptr[a*8 +: 8]);
      if (stuck) break;
      tick($urandom_range(0, 40));
      if (bad_stop && ptr == 0) send_rx(8'($urandom_range(0, 255)), 1'b0);
      for (int k = 3; k >= 0; k--) send_rx(mem[ptr+k], 1'b1);
      for (int k = 0; k < 4; k++) begin
        if (mem[ptr+k] == 8'h00) begin
          expect_tx("hlt", 8'h04);
          done = 1'b1;
          break;
        end
        expect_tx("print_cmd", 8'h03);
        expect_tx("print_chr", mem[ptr+k]);
      end
      ptr = ptr + 32'd4;
    end
    send_rx(8'h01, 1'b1);
    tick(300);
    check("done_idle", 32'(tx), 32'd1);
    check("done_quiet", 32'(txq.size()), 32'd0);
  endtask

  initial begin
    int n;
    res_n = 1'b0;
    rx = 1'b1;
    tick(2);
    check("rst_tx0", 32'(tx), 32'd1);

    do_reset(); load_str("Hi!");    run_program(1'b0);
    do_reset(); load_str("ABCDEF"); run_program(1'b0);
    do_reset(); load_str("");       run_program(1'b0);
    do_reset(); load_str("XY");     run_program(1'b1);

    // reset in the middle of the second address byte
    do_reset(); load_str("Go");
    expect_tx("r_cmd", 8'h01);
    expect_tx("r_addr0", 8'h00);
    n = 0;
    while (tx !== 1'b0 && n < 2000) begin
      tick(1);
      n++;
    end
    check("addr1_start", 32'(tx), 32'd0);
    tick(15);
    check("pre_rst_tx", 32'(tx), 32'd0);
    #2 res_n = 1'b0;
    #1 check("rst_abort_tx", 32'(tx), 32'd1);
    tick(150);
    check("rst_hold_tx", 32'(tx), 32'd1);
    res_n = 1'b1;
    clear_mon();
    run_program(1'b0);

    for (int r = 0; r < 4; r++) begin
      do_reset();
      load_rand($urandom_range(0, 9));
      run_program(1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
